// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg -- shared definitions for the decode stage.
//   * RV32I base opcode constants and the RV32M funct7 marker
//   * decode FSM state encoding (state_t)
//   * immediate-format enum (imm_fmt_t) and opcode -> format mapping
//   * base-opcode legality helper
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // funct7 value that turns an OP instruction into an RV32M mul/div.
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,   // R-type and anything without an immediate
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  // Map an opcode to the immediate layout it uses.
  function automatic imm_fmt_t imm_format(input logic [6:0] opcode);
    imm_fmt_t fmt;
    case (opcode)
      OPC_OP_IMM,
      OPC_LOAD,
      OPC_JALR,
      OPC_SYSTEM,
      OPC_MISC_MEM: fmt = IMM_I;
      OPC_STORE:    fmt = IMM_S;
      OPC_BRANCH:   fmt = IMM_B;
      OPC_LUI,
      OPC_AUIPC:    fmt = IMM_U;
      OPC_JAL:      fmt = IMM_J;
      default:      fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  // True for the eleven RV32I base opcodes.
  function automatic logic is_base_opcode(input logic [6:0] opcode);
    logic hit;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen -- combinational RV32I immediate generator.
// Ports:
//   i_instruction [31:0]  raw instruction word
//   o_imm         [31:0]  sign-extended immediate (0 for formats without one)
// -----------------------------------------------------------------------------
module imm_gen
  import cpu_pkg::*;
(
  input  logic [31:0] i_instruction,
  output logic [31:0] o_imm
);

  imm_fmt_t fmt;

  assign fmt = imm_format(i_instruction[6:0]);

  // Assemble the immediate according to the instruction format.
  always_comb begin
    o_imm = 32'd0;
    case (fmt)
      IMM_I: o_imm = {{20{i_instruction[31]}}, i_instruction[31:20]};
      IMM_S: o_imm = {{20{i_instruction[31]}}, i_instruction[31:25],
                      i_instruction[11:7]};
      IMM_B: o_imm = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                      i_instruction[30:25], i_instruction[11:8], 1'b0};
      IMM_U: o_imm = {i_instruction[31:12], 12'd0};
      IMM_J: o_imm = {{11{i_instruction[31]}}, i_instruction[31],
                      i_instruction[19:12], i_instruction[20],
                      i_instruction[30:21], 1'b0};
      default: o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode -- instruction fetch sequencer and RV32I decoder.
// Requests a fetch, waits (with timeout) for the fetched word, decodes it into
// registered fields and offers it to execute through a valid/ready handshake.
//
// Parameter:
//   FETCH_TIMEOUT   WAIT cycles allowed before the fetch is aborted (1..255)
// Build option:
//   DECODE_RV32M_EN defined   -> OP with funct7=0000001 is legal, o_is_mul=1
//   DECODE_RV32M_EN undefined -> that encoding is illegal, o_is_mul tied 0
// Ports:
//   clk, reset (synchronous, active-low)
//   i_enable, i_pc          next-instruction request and its address
//   o_fetch_enable          one-cycle fetch start pulse
//   i_fetch_completed, i_instruction  fetch completion and fetched word
//   o_valid / i_ready       handshake to execute
//   i_flush                 discard in-flight or held instruction
//   o_pc, o_opcode, o_rd, o_rs1, o_rs2, o_funct3, o_funct7, o_imm,
//   o_illegal, o_is_mul     decoded instruction (held while o_valid)
//   o_fetch_error           one-cycle pulse on fetch timeout
// -----------------------------------------------------------------------------
module decode
  import cpu_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic [31:0] i_pc,
  output logic        o_fetch_enable,
  input  logic        i_fetch_completed,
  input  logic [31:0] i_instruction,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_flush,
  output logic [31:0] o_pc,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [31:0] o_imm,
  output logic        o_illegal,
  output logic        o_is_mul,
  output logic        o_fetch_error
);

  // Counter holds the number of WAIT cycles already completed, so the
  // last permitted WAIT cycle is the one where it equals FETCH_TIMEOUT-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_cnt;
  logic        discard;
  logic        timeout_hit;
  logic        capture;
  logic [31:0] imm_value;
  logic        dec_illegal;
  logic        dec_is_mul;
  logic        base_illegal;
  logic        mul_hit;

  imm_gen u_imm_gen (
    .i_instruction (i_instruction),
    .o_imm         (imm_value)
  );

  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

  // A completion is kept only if neither an earlier nor a same-cycle flush
  // has marked it for discard.
  assign capture = (state == ST_WAIT) && i_fetch_completed && !discard && !i_flush;

  // Legality and RV32M classification of the incoming word.
  always_comb begin
    base_illegal = (i_instruction[1:0] != 2'b11) || !is_base_opcode(i_instruction[6:0]);
    mul_hit      = (i_instruction[6:0] == OPC_OP) && (i_instruction[31:25] == FUNCT7_MULDIV);
`ifdef DECODE_RV32M_EN
    dec_illegal  = base_illegal;
    dec_is_mul   = mul_hit && !base_illegal;
`else
    dec_illegal  = base_illegal || mul_hit;
    dec_is_mul   = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        // Flush in IDLE is a no-op but also masks a same-cycle enable.
        if (i_enable && !i_flush) begin
          next_state = ST_REQ;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_fetch_completed) begin
          if (discard || i_flush) begin
            next_state = ST_IDLE;
          end else begin
            next_state = ST_OUT;
          end
        end else if (timeout_hit) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_OUT: begin
        // o_valid is high throughout OUT, so transfer reduces to ready & !flush.
        if (i_flush) begin
          next_state = ST_IDLE;
        end else if (i_ready) begin
          if (i_enable) begin
            next_state = ST_REQ;
          end else begin
            next_state = ST_IDLE;
          end
        end else begin
          next_state = ST_OUT;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    o_valid        = (state == ST_OUT);
    o_fetch_enable = (state == ST_REQ);
    if ((state == ST_WAIT) && !i_fetch_completed && timeout_hit) begin
      o_fetch_error = 1'b1;
    end else begin
      o_fetch_error = 1'b0;
    end
  end

  // WAIT cycle counter; cleared in REQ, which is the only way into WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= 8'd0;
    end else if (state == ST_REQ) begin
      wait_cnt <= 8'd0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Discard flag: set by a flush while a fetch is outstanding, cleared once
  // WAIT is left (completion swallowed or timeout).
  always_ff @(posedge clk) begin
    if (!reset) begin
      discard <= 1'b0;
    end else if ((state == ST_WAIT) && (next_state != ST_WAIT)) begin
      discard <= 1'b0;
    end else if (i_flush && ((state == ST_REQ) || (state == ST_WAIT))) begin
      discard <= 1'b1;
    end else begin
      discard <= discard;
    end
  end

  // Program counter of the instruction being requested.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_pc <= 32'd0;
    end else if (next_state == ST_REQ) begin
      o_pc <= i_pc;
    end else begin
      o_pc <= o_pc;
    end
  end

  // Decoded instruction fields, captured on an accepted completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_opcode  <= 7'd0;
      o_rd      <= 5'd0;
      o_rs1     <= 5'd0;
      o_rs2     <= 5'd0;
      o_funct3  <= 3'd0;
      o_funct7  <= 7'd0;
      o_imm     <= 32'd0;
      o_illegal <= 1'b0;
      o_is_mul  <= 1'b0;
    end else if (capture) begin
      o_opcode  <= i_instruction[6:0];
      o_rd      <= i_instruction[11:7];
      o_rs1     <= i_instruction[19:15];
      o_rs2     <= i_instruction[24:20];
      o_funct3  <= i_instruction[14:12];
      o_funct7  <= i_instruction[31:25];
      o_imm     <= imm_value;
      o_illegal <= dec_illegal;
      o_is_mul  <= dec_is_mul;
    end else begin
      o_opcode  <= o_opcode;
      o_rd      <= o_rd;
      o_rs1     <= o_rs1;
      o_rs2     <= o_rs2;
      o_funct3  <= o_funct3;
      o_funct7  <= o_funct7;
      o_imm     <= o_imm;
      o_illegal <= o_illegal;
      o_is_mul  <= o_is_mul;
    end
  end

endmodule

// File: tb/tb_decode.sv
// -----------------------------------------------------------------------------
// tb_decode -- directed self-checking bench for decode (FETCH_TIMEOUT=4).
// Expected decode results are queued when a completion is driven and
// compared while the DUT presents the instruction.
// -----------------------------------------------------------------------------
module tb_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic [31:0] i_pc;
  logic        o_fetch_enable;
  logic        i_fetch_completed;
  logic [31:0] i_instruction;
  logic        o_valid;
  logic        i_ready;
  logic        i_flush;
  logic [31:0] o_pc;
  logic [6:0]  o_opcode;
  logic [4:0]  o_rd;
  logic [4:0]  o_rs1;
  logic [4:0]  o_rs2;
  logic [2:0]  o_funct3;
  logic [6:0]  o_funct7;
  logic [31:0] o_imm;
  logic        o_illegal;
  logic        o_is_mul;
  logic        o_fetch_error;

  always #5 clk = ~clk;

  decode #(.FETCH_TIMEOUT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_enable          (i_enable),
    .i_pc              (i_pc),
    .o_fetch_enable    (o_fetch_enable),
    .i_fetch_completed (i_fetch_completed),
    .i_instruction     (i_instruction),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .i_flush           (i_flush),
    .o_pc              (o_pc),
    .o_opcode          (o_opcode),
    .o_rd              (o_rd),
    .o_rs1             (o_rs1),
    .o_rs2             (o_rs2),
    .o_funct3          (o_funct3),
    .o_funct7          (o_funct7),
    .o_imm             (o_imm),
    .o_illegal         (o_illegal),
    .o_is_mul          (o_is_mul),
    .o_fetch_error     (o_fetch_error)
  );

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
    logic        is_mul;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] imm, input logic ill, input logic mul);
    exp_t e;
    e.pc      = pc;
    e.opcode  = instr[6:0];
    e.rd      = instr[11:7];
    e.rs1     = instr[19:15];
    e.rs2     = instr[24:20];
    e.funct3  = instr[14:12];
    e.funct7  = instr[31:25];
    e.imm     = imm;
    e.illegal = ill;
    e.is_mul  = mul;
    sb.push_back(e);
  endtask

  // Compare presented fields with the head of the scoreboard (not popped).
  task automatic cmp_head(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected queued entry", tag);
    end else begin
      e = sb[0];
      check({tag, ".pc"},      o_pc,               e.pc);
      check({tag, ".opcode"},  {25'd0, o_opcode},  {25'd0, e.opcode});
      check({tag, ".rd"},      {27'd0, o_rd},      {27'd0, e.rd});
      check({tag, ".rs1"},     {27'd0, o_rs1},     {27'd0, e.rs1});
      check({tag, ".rs2"},     {27'd0, o_rs2},     {27'd0, e.rs2});
      check({tag, ".funct3"},  {29'd0, o_funct3},  {29'd0, e.funct3});
      check({tag, ".funct7"},  {25'd0, o_funct7},  {25'd0, e.funct7});
      check({tag, ".imm"},     o_imm,              e.imm);
      check({tag, ".illegal"}, {31'd0, o_illegal}, {31'd0, e.illegal});
      check({tag, ".is_mul"},  {31'd0, o_is_mul},  {31'd0, e.is_mul});
    end
  endtask

  task automatic pop_exp();
    if (sb.size() != 0) begin
      void'(sb.pop_front());
    end
  endtask

  // IDLE -> REQ -> WAIT -> completion -> OUT; leaves the DUT in OUT.
  task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] imm, input logic ill, input logic mul);
    i_enable = 1'b1;
    i_pc     = pc;
    step();
    check({tag, ".fe_req"}, {31'd0, o_fetch_enable}, 32'd1);
    i_enable = 1'b0;
    step();
    check({tag, ".fe_wait"}, {31'd0, o_fetch_enable}, 32'd0);
    i_fetch_completed = 1'b1;
    i_instruction     = instr;
    push_exp(pc, instr, imm, ill, mul);
    step();
    i_fetch_completed = 1'b0;
    check({tag, ".valid"}, {31'd0, o_valid}, 32'd1);
    cmp_head(tag);
  endtask

  logic exp_mul_ill;
  logic exp_mul_flag;

  initial begin
`ifdef DECODE_RV32M_EN
    exp_mul_ill  = 1'b0;
    exp_mul_flag = 1'b1;
`else
    exp_mul_ill  = 1'b1;
    exp_mul_flag = 1'b0;
`endif
    reset             = 1'b0;
    i_enable          = 1'b0;
    i_pc              = 32'd0;
    i_fetch_completed = 1'b0;
    i_instruction     = 32'd0;
    i_ready           = 1'b0;
    i_flush           = 1'b0;

    // Reset state
    step();
    step();
    check("rst.valid", {31'd0, o_valid},        32'd0);
    check("rst.fe",    {31'd0, o_fetch_enable}, 32'd0);
    check("rst.err",   {31'd0, o_fetch_error},  32'd0);
    check("rst.ill",   {31'd0, o_illegal},      32'd0);
    check("rst.mul",   {31'd0, o_is_mul},       32'd0);
    check("rst.pc",    o_pc,                    32'd0);
    check("rst.imm",   o_imm,                   32'd0);
    check("rst.op",    {25'd0, o_opcode},       32'd0);
    reset = 1'b1;
    step();

    // addi x1, x0, 5
    fetch("addi", 32'h0000_0100, 32'h0050_0093, 32'h0000_0005, 1'b0, 1'b0);
    i_ready = 1'b1;
    step();
    pop_exp();
    i_ready = 1'b0;
    check("addi.drop", {31'd0, o_valid}, 32'd0);

    // beq with negative offset
    fetch("beq", 32'h0000_0104, 32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b0, 1'b0);

    // Hold in OUT with ready low: outputs stable, no new fetch
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold.valid", {31'd0, o_valid},        32'd1);
      check("hold.fe",    {31'd0, o_fetch_enable}, 32'd0);
      cmp_head("hold");
    end
    i_enable = 1'b1;
    i_ready  = 1'b1;
    i_pc     = 32'h0000_0200;
    step();
    pop_exp();
    check("xfer.valid", {31'd0, o_valid},        32'd0);
    check("xfer.fe",    {31'd0, o_fetch_enable}, 32'd1);
    check("xfer.pc",    o_pc,                    32'h0000_0200);
    i_enable = 1'b0;
    i_ready  = 1'b0;
    step();
    i_fetch_completed = 1'b1;
    i_instruction     = 32'h0220_8033;
    push_exp(32'h0000_0200, 32'h0220_8033, 32'd0, exp_mul_ill, exp_mul_flag);
    step();
    i_fetch_completed = 1'b0;
    check("mul.valid", {31'd0, o_valid}, 32'd1);
    cmp_head("mul");
    i_ready = 1'b1;
    step();
    pop_exp();
    i_ready = 1'b0;
    check("mul.drop", {31'd0, o_valid}, 32'd0);

    // Flush in WAIT, completion afterwards is discarded
    i_enable = 1'b1;
    i_pc     = 32'h0000_0300;
    step();
    i_enable = 1'b0;
    step();
    i_flush = 1'b1;
    step();
    i_flush           = 1'b0;
    i_fetch_completed = 1'b1;
    i_instruction     = 32'h0050_0093;
    step();
    i_fetch_completed = 1'b0;
    check("wflush.valid0", {31'd0, o_valid}, 32'd0);
    step();
    check("wflush.valid1", {31'd0, o_valid}, 32'd0);
    i_enable = 1'b1;
    i_pc     = 32'h0000_0310;
    step();
    check("wflush.idle", {31'd0, o_fetch_enable}, 32'd1);
    i_enable = 1'b0;

    // Timeout: 4 WAIT cycles, error on the 4th only
    step();
    check("to.w1", {31'd0, o_fetch_error}, 32'd0);
    step();
    check("to.w2", {31'd0, o_fetch_error}, 32'd0);
    step();
    check("to.w3", {31'd0, o_fetch_error}, 32'd0);
    step();
    check("to.w4", {31'd0, o_fetch_error}, 32'd1);
    step();
    check("to.after", {31'd0, o_fetch_error}, 32'd0);
    check("to.fe",    {31'd0, o_fetch_enable}, 32'd0);
    i_fetch_completed = 1'b1;
    i_instruction     = 32'h0050_0093;
    step();
    i_fetch_completed = 1'b0;
    check("to.late", {31'd0, o_valid}, 32'd0);

    // lui, then flush in OUT with ready and enable high
    fetch("lui", 32'h0000_0400, 32'h1234_5037, 32'h1234_5000, 1'b0, 1'b0);
    i_flush  = 1'b1;
    i_ready  = 1'b1;
    i_enable = 1'b1;
    step();
    pop_exp();
    check("oflush.valid", {31'd0, o_valid},        32'd0);
    check("oflush.fe",    {31'd0, o_fetch_enable}, 32'd0);
    i_ready = 1'b0;
    // Flush in IDLE masks the enable
    step();
    check("iflush.fe", {31'd0, o_fetch_enable}, 32'd0);
    i_flush  = 1'b0;
    i_enable = 1'b0;
    step();

    // Low bits not 11 -> illegal
    fetch("ill", 32'h0000_0500, 32'h0000_0010, 32'd0, 1'b1, 1'b0);
    i_ready = 1'b1;
    step();
    pop_exp();
    i_ready = 1'b0;

    // Reset mid-WAIT drops the fetch
    i_enable = 1'b1;
    i_pc     = 32'h0000_0600;
    step();
    i_enable = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rwait.pc", o_pc, 32'd0);
    i_fetch_completed = 1'b1;
    i_instruction     = 32'h0050_0093;
    step();
    i_fetch_completed = 1'b0;
    check("rwait.valid", {31'd0, o_valid},        32'd0);
    check("rwait.fe",    {31'd0, o_fetch_enable}, 32'd0);
    check("rwait.op",    {25'd0, o_opcode},       32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
